// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch stage and its consumers.
// Holds the NOP encoding, the default reset PC and sequential increment, and
// the IF/ID bundle type that the decode stage reuses.
package fetch_redirect_unit_pkg;

    localparam int          PC_W_DEF    = 32;
    localparam int          INSTR_W_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INC_DEF  = 4;
    localparam int          CNT_W_DEF   = 16;

    // All-zero instruction word used to fill a killed IF/ID slot
    localparam logic [INSTR_W_DEF-1:0] NOP = {INSTR_W_DEF{1'b0}};

    // IF/ID pipeline bundle at the default widths
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc_plus;
        logic                   valid;
    } ifid_t;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : fetch address driven by the fetch stage (master)
//   imem_rdata : instruction at imem_addr, same-cycle read (slave drives)
interface fetch_redirect_unit_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_redirect_unit_flopenrc_n.sv
// Parameterised flop with enable and synchronous clear, active-low async reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RST_VAL
//   en    : load d when high
//   clr   : synchronous clear to zero; beats en
//   d / q : data in / registered data out
module flopenrc_n #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // State register: reset, then clear, then load, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns the fetch PC, the instruction-memory address and the
// IF/ID register. Redirects on taken branches, kills the wrong-path slot and
// buffers a redirect that arrives during a fetch stall.
//   clk, reset      : clock; asynchronous active-low reset
//   stallF, stallD  : hold fetch PC / hold IF/ID
//   flushD          : clear IF/ID
//   pcSrc           : taken-branch redirect, branchTarget is its address
//   imem            : instruction-memory bus (address out, read data in)
//   instrD, pcPlusD, validD : IF/ID contents
//   redirect_count  : saturating count of cycles with pcSrc=1
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
    parameter int              PC_INC   = PC_INC_DEF,
    parameter int              CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallF,
    input  logic                stallD,
    input  logic                flushD,
    input  logic                pcSrc,
    input  logic [PC_W-1:0]     branchTarget,
    fetch_redirect_unit_if.master imem,
    output logic [INSTR_W-1:0]  instrD,
    output logic [PC_W-1:0]     pcPlusD,
    output logic                validD,
    output logic [CNT_W-1:0]    redirect_count
);

    logic [PC_W-1:0]  pc_f_r;
    logic [PC_W-1:0]  pc_next_s;
    logic [PC_W-1:0]  pc_plus_s;
    logic             pending_r;
    logic [PC_W-1:0]  pend_target_r;
    logic             kill_s;
    logic             buffer_s;
    logic [CNT_W-1:0] cnt_r;

    // Sequential successor wraps naturally at PC_W bits
    assign pc_plus_s = pc_f_r + PC_W'(PC_INC);

    // A redirect seen while fetch is stalled is parked until the stall drops
    assign buffer_s = pcSrc & stallF;

    // Wrong-path slot dies on flush, live redirect, or a parked redirect taking effect
    assign kill_s = flushD | pcSrc | (pending_r & ~stallF);

    // Next-PC select: live redirect beats parked redirect beats sequential
    always_comb begin
        pc_next_s = pc_plus_s;
        if (pcSrc) begin
            pc_next_s = branchTarget;
        end else if (pending_r) begin
            pc_next_s = pend_target_r;
        end else begin
            pc_next_s = pc_plus_s;
        end
    end

    flopenrc_n #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc_f (
        .clk(clk), .rst_n(reset), .en(~stallF), .clr(1'b0),
        .d(pc_next_s), .q(pc_f_r)
    );

    // pending drops on any unstalled edge: it is either consumed or overridden by a live redirect
    flopenrc_n #(.W(1), .RST_VAL(1'b0)) u_pending (
        .clk(clk), .rst_n(reset), .en(buffer_s), .clr(~stallF),
        .d(1'b1), .q(pending_r)
    );

    // Newest redirect during a stall overwrites the parked target
    flopenrc_n #(.W(PC_W), .RST_VAL({PC_W{1'b0}})) u_pend_target (
        .clk(clk), .rst_n(reset), .en(buffer_s), .clr(1'b0),
        .d(branchTarget), .q(pend_target_r)
    );

    // IF/ID fields: kill is a clear, so it wins over stallD
    flopenrc_n #(.W(INSTR_W), .RST_VAL({INSTR_W{1'b0}})) u_instr_d (
        .clk(clk), .rst_n(reset), .en(~stallD), .clr(kill_s),
        .d(imem.imem_rdata), .q(instrD)
    );

    flopenrc_n #(.W(PC_W), .RST_VAL({PC_W{1'b0}})) u_pc_plus_d (
        .clk(clk), .rst_n(reset), .en(~stallD), .clr(kill_s),
        .d(pc_plus_s), .q(pcPlusD)
    );

    flopenrc_n #(.W(1), .RST_VAL(1'b0)) u_valid_d (
        .clk(clk), .rst_n(reset), .en(~stallD), .clr(kill_s),
        .d(1'b1), .q(validD)
    );

    // Saturating redirect counter, counts every pcSrc cycle regardless of stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (pcSrc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign imem.imem_addr = pc_f_r;
    assign redirect_count = cnt_r;

endmodule
